// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its scanout/writer clients and the pixel RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_rvalid;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_miss;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  scan_req, scan_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output scan_rvalid, scan_rdata, scan_miss, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output scan_req, scan_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  scan_rvalid, scan_rdata, scan_miss, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout reads have priority, writer pixels are
// buffered in a small FIFO and drained into idle slots, with a starvation-forced write.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 64
) (
  input  logic                        in_clk,
  input  logic                        rst_n,
  vga_fb_arbiter_if.slave             bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err_miss,
  input  logic                        err_clr
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam bit               FORCE_EN   = (STARVE_MAX != 0);

  // FIFO storage: address and data kept side by side, no reset needed
  logic [ADDR_W-1:0] ent_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] ent_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic              rd_pend_q;
  logic              scan_rvalid_q;
  logic [DATA_W-1:0] scan_rdata_q;
  logic              scan_miss_q;
  logic              err_miss_q, err_miss_d;

  logic fifo_empty;
  logic fifo_full;
  logic wr_ready;
  logic push;
  logic pop;
  logic force_wr;
  logic scan_grant;
  logic scan_drop;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);
  assign wr_ready   = rst_n & ~fifo_full;
  assign push       = bus.wr_valid & wr_ready;

  // Grant decision: forced write beats scanout, scanout beats an opportunistic write
  always_comb begin
    force_wr   = 1'b0;
    scan_grant = 1'b0;
    pop        = 1'b0;
    if (rst_n) begin
      force_wr   = FORCE_EN & ~fifo_empty & (starve_q == STARVE_LIM);
      scan_grant = bus.scan_req & ~force_wr;
      pop        = ~fifo_empty & (force_wr | ~bus.scan_req);
    end
  end

  assign scan_drop = force_wr & bus.scan_req;

  assign bus.mem_en    = pop | scan_grant;
  assign bus.mem_we    = pop;
  assign bus.mem_addr  = pop ? ent_addr_q[rd_ptr_q] : bus.scan_addr;
  assign bus.mem_wdata = ent_data_q[rd_ptr_q];

  assign bus.wr_ready    = wr_ready;
  assign bus.scan_rvalid = scan_rvalid_q;
  assign bus.scan_rdata  = scan_rdata_q;
  assign bus.scan_miss   = scan_miss_q;
  assign fifo_level      = level_q;
  assign err_miss        = err_miss_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // The counter measures how long the current head has been waiting for a slot
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    err_miss_d = err_miss_q;
    if (scan_drop) begin
      err_miss_d = 1'b1;
    end else if (err_clr) begin
      err_miss_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= bus.wr_addr;
      ent_data_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      starve_q <= starve_d;
    end
  end

  // Two-stage read pipe: RAM answers one cycle after the grant, then it is registered
  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      rd_pend_q     <= 1'b0;
      scan_rvalid_q <= 1'b0;
      scan_rdata_q  <= '0;
      scan_miss_q   <= 1'b0;
      err_miss_q    <= 1'b0;
    end else begin
      rd_pend_q     <= scan_grant;
      scan_rvalid_q <= rd_pend_q;
      if (rd_pend_q) begin
        scan_rdata_q <= bus.mem_rdata;
      end
      scan_miss_q   <= scan_drop;
      err_miss_q    <= err_miss_d;
    end
  end
endmodule
